demux1to8_deser: RTL

Serial-to-parallel collector: the receive-side counterpart of the 8-to-1 bit selector. It routes each accepted serial bit into one of 8 output slots, using an internal 3-bit slot index that plays the role of the selector. Once 8 bits are collected, it presents the byte on a valid/ready output. It sits on the receive end of the team's bit-serial links and drives byte-wide consumers.

---
 rtl/demux1to8_deser.sv | 128 ++++++++++++
 1 files changed

// File: rtl/demux1to8_deser.sv
// Serial-to-parallel collector: routes accepted bits into 8 slots and presents the byte on valid/ready.
// Optional even-parity trailer bit and par_err output when DEMUX8_PARITY_EN is defined.
module demux1to8_deser #(
  parameter bit MSB_FIRST = 1'b0
) (
  input  logic       clk,
  input  logic       rst_n,
  input  logic       clr,
  input  logic       din,
  input  logic       din_valid,
  output logic       din_ready,
  output logic [7:0] out,
  output logic       out_valid,
  input  logic       out_ready,
  output logic [2:0] sel
`ifdef DEMUX8_PARITY_EN
  ,
  output logic       par_err
`endif
);

  logic [2:0] r_sel;
  logic [7:0] r_acc;
  logic [7:0] r_out;
  logic       r_out_valid;

  logic [2:0] w_slot;
  logic [7:0] w_acc_merged;
  logic       w_out_free;
  logic       w_consume;
  logic       w_last_bit;
  logic       w_din_ready;
  logic       w_accept;
  logic       w_commit;
  logic [7:0] w_commit_byte;

  assign w_slot     = MSB_FIRST ? (3'd7 - r_sel) : r_sel;
  assign w_out_free = !r_out_valid || out_ready;
  assign w_consume  = r_out_valid && out_ready;
  assign w_last_bit = (r_sel == 3'd7);
  assign w_accept   = din_valid && w_din_ready;

  // Accumulator view with the incoming bit already dropped into its slot.
  generate
    for (genvar gi = 0; gi < 8; gi++) begin : g_merge
      assign w_acc_merged[gi] = (w_slot == 3'(gi)) ? din : r_acc[gi];
    end
  endgenerate

`ifdef DEMUX8_PARITY_EN
  localparam logic [0:0] ST_COLLECT = 1'b0;
  localparam logic [0:0] ST_PARITY  = 1'b1;

  logic [0:0] r_state;
  logic       r_par_err;
  logic       w_in_parity;
  logic       w_enter_parity;
  logic       w_par_err_next;

  assign w_in_parity    = (r_state == ST_PARITY);
  // Only the parity bit completes a byte, so only it waits for the output slot.
  assign w_din_ready    = !clr && (w_in_parity ? w_out_free : 1'b1);
  assign w_commit       = w_accept && w_in_parity;
  assign w_enter_parity = w_accept && !w_in_parity && w_last_bit;
  assign w_par_err_next = (^r_acc) ^ din;
  assign w_commit_byte  = r_acc;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_state <= ST_COLLECT;
    end else if (clr || w_commit) begin
      r_state <= ST_COLLECT;
    end else if (w_enter_parity) begin
      r_state <= ST_PARITY;
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_par_err <= 1'b0;
    end else if (w_commit) begin
      r_par_err <= w_par_err_next;
    end
  end

  assign par_err = r_par_err;
`else
  assign w_din_ready   = !clr && !(w_last_bit && !w_out_free);
  assign w_commit      = w_accept && w_last_bit;
  assign w_commit_byte = w_acc_merged;
`endif

  // Slot index and assembly register; a bit accepted at sel==7 wraps sel to 0.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_sel <= 3'd0;
      r_acc <= 8'd0;
    end else if (clr) begin
      r_sel <= 3'd0;
      r_acc <= 8'd0;
    end else if (w_commit) begin
      r_sel <= 3'd0;
      r_acc <= 8'd0;
    end else if (w_accept) begin
      r_sel <= r_sel + 3'd1;
      r_acc <= w_acc_merged;
    end
  end

  // Output holding register: a same-edge consume and commit keeps out_valid high.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_out       <= 8'd0;
      r_out_valid <= 1'b0;
    end else if (w_commit) begin
      r_out       <= w_commit_byte;
      r_out_valid <= 1'b1;
    end else if (w_consume) begin
      r_out_valid <= 1'b0;
    end
  end

  assign din_ready = w_din_ready;
  assign out       = r_out;
  assign out_valid = r_out_valid;
  assign sel       = r_sel;

endmodule
